// File: rtl/button_pkg.sv
// Shared types and constants for the bouncing push-button stimulus generator.
package button_pkg;

  localparam int unsigned CNT_W     = 24;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it becomes 1.
module lfsr16
  import button_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED_EFF;
    end else if (value[0]) begin
      value <= (value >> 1) ^ LFSR_MASK;
    end else begin
      value <= value >> 1;
    end
  end

endmodule

// File: rtl/button_press_gen.sv
// Turns a one-shot start into an active-low press with pseudo-random contact
// bounce on both edges, a stable hold, and a release gap before done.
module button_press_gen
  import button_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 250000,
  parameter int unsigned GLITCH_MAX    = 4096,
  parameter int unsigned HOLD_MIN      = 600000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] hold_cycles,
  input  logic             bounce_en,
  output logic             btn_n,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIN_LEN  = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LEN = CNT_W'(HOLD_MIN);
  localparam logic [15:0]      G_MASK   = 16'(GLITCH_MAX - 1);
  localparam bit               NO_WIN   = (BOUNCE_CYCLES == 0);

  state_t           state, state_d;
  logic             btn_d, busy_d, done_d;
  logic [CNT_W-1:0] win_cnt, win_d;
  logic [CNT_W-1:0] glitch_cnt, glitch_d;
  logic [CNT_W-1:0] hold_cnt, hold_d;
  logic [CNT_W-1:0] hold_eff, hold_eff_d;
  logic             bounce_q, bounce_d;
  logic [15:0]      lfsr;
  logic [CNT_W-1:0] glitch_w;
  logic [CNT_W-1:0] req_eff;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (lfsr)
  );

  // Glitch width is never zero: 1..GLITCH_MAX.
  assign glitch_w = CNT_W'(lfsr & G_MASK) + CNT_W'(1);
  assign req_eff  = (hold_cycles < HOLD_LEN) ? HOLD_LEN : hold_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      btn_n      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_cnt    <= '0;
      glitch_cnt <= '0;
      hold_cnt   <= '0;
      hold_eff   <= '0;
      bounce_q   <= 1'b0;
    end else begin
      state      <= state_d;
      btn_n      <= btn_d;
      busy       <= busy_d;
      done       <= done_d;
      win_cnt    <= win_d;
      glitch_cnt <= glitch_d;
      hold_cnt   <= hold_d;
      hold_eff   <= hold_eff_d;
      bounce_q   <= bounce_d;
    end
  end

  always_comb begin
    state_d    = state;
    btn_d      = btn_n;
    busy_d     = busy;
    done_d     = 1'b0;
    win_d      = win_cnt;
    glitch_d   = glitch_cnt;
    hold_d     = hold_cnt;
    hold_eff_d = hold_eff;
    bounce_d   = bounce_q;
    case (state)
      IDLE: begin
        btn_d = 1'b1;
        // The done cycle still reads as IDLE, so a start there is dropped.
        if (start && !done) begin
          hold_eff_d = req_eff;
          bounce_d   = bounce_en;
          busy_d     = 1'b1;
          btn_d      = 1'b0;
          glitch_d   = glitch_w;
          if (NO_WIN) begin
            state_d = HOLD;
            hold_d  = req_eff;
          end else begin
            state_d = BOUNCE_IN;
            win_d   = WIN_LEN;
          end
        end
      end
      BOUNCE_IN, BOUNCE_OUT: begin
        if (win_cnt <= CNT_W'(1)) begin
          if (state == BOUNCE_IN) begin
            state_d = HOLD;
            btn_d   = 1'b0;
            hold_d  = hold_eff;
          end else begin
            state_d = GAP;
            btn_d   = 1'b1;
            hold_d  = HOLD_LEN;
          end
        end else begin
          win_d = win_cnt - CNT_W'(1);
          if (glitch_cnt <= CNT_W'(1)) begin
            glitch_d = glitch_w;
            if (bounce_q) btn_d = ~btn_n;
          end else begin
            glitch_d = glitch_cnt - CNT_W'(1);
          end
        end
      end
      HOLD: begin
        btn_d = 1'b0;
        if (hold_cnt <= CNT_W'(1)) begin
          btn_d = 1'b1;
          if (NO_WIN) begin
            state_d = GAP;
            hold_d  = HOLD_LEN;
          end else begin
            state_d  = BOUNCE_OUT;
            win_d    = WIN_LEN;
            glitch_d = glitch_w;
          end
        end else begin
          hold_d = hold_cnt - CNT_W'(1);
        end
      end
      GAP: begin
        btn_d = 1'b1;
        if (hold_cnt <= CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        btn_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
